// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Forwarding select encoding and memory-wait FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    TMO
  } mem_state_t;

  localparam logic [3:0] PC_REG = 4'd15;

  // M beats W; R15 reads come from the PC path and are never forwarded.
  function automatic fwd_sel_t fwd_sel(
    input logic [3:0] ra,
    input logic [3:0] wa_m,
    input logic       rw_m,
    input logic [3:0] wa_w,
    input logic       rw_w
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (ra != PC_REG) begin
      if (rw_m && (wa_m == ra)) begin
        sel = FWD_M;
      end else if (rw_w && (wa_w == ra)) begin
        sel = FWD_W;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: stage addresses/enables in,
// forwarding selects, pipe-register stall/flush controls and counters out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);

  logic [3:0]       RA1D, RA2D;
  logic [3:0]       RA1E, RA2E;
  logic [3:0]       WA3E, WA3M, WA3W;
  logic             RegWriteE, RegWriteM, RegWriteW;
  logic             MemToRegE;
  logic             PCSrcD, PCSrcE, PCSrcM, PCSrcW;
  logic             BranchTakenE;
  logic             MemReqM, MemAckM;

  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic             MemErr;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    output RegWriteE, RegWriteM, RegWriteW, MemToRegE,
    output PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
    output MemReqM, MemAckM,
    input  ForwardAE, ForwardBE,
    input  StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, MemErr,
    input  StallCnt, FlushCnt
  );

  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    input  RegWriteE, RegWriteM, RegWriteW, MemToRegE,
    input  PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
    input  MemReqM, MemAckM,
    output ForwardAE, ForwardBE,
    output StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, MemErr,
    output StallCnt, FlushCnt
  );

endinterface

// File: rtl/hazard_ctrl_mem_wait_fsm.sv
// M-stage memory/camera wait FSM: stall is combinational (zero-cycle), a missing
// ack for MEM_TIMEOUT WAIT cycles drops the access and pulses o_mem_err once.
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic i_ack,
  output logic o_mem_stall,
  output logic o_mem_err
);

  localparam int             TW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(MEM_TIMEOUT - 1);
  localparam logic [TW-1:0]  CNT_ONE  = TW'(1);

  mem_state_t    r_state, w_state_nxt;
  logic [TW-1:0] r_cnt, w_cnt_nxt;
  logic          w_stall, w_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        // An ack in the request cycle completes without any stall.
        if (i_req && !i_ack) begin
          w_stall     = 1'b1;
          w_state_nxt = WAIT;
          w_cnt_nxt   = '0;
        end
      end
      WAIT: begin
        w_stall = 1'b1;
        if (i_ack) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == TMO_LAST) begin
          w_state_nxt = TMO;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      TMO: begin
        w_err       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (!reset) begin
      w_stall = 1'b0;
      w_err   = 1'b0;
    end
  end

  assign o_mem_stall = w_stall;
  assign o_mem_err   = w_err;

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: combinational forwarding and stall/flush
// controls; optional saturating stall/flush counters under HAZARD_PERF_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       reset,
  hazard_ctrl_if.slave hif
);

  fwd_sel_t w_fwd_a, w_fwd_b;
  logic     w_ldr_stall;
  logic     w_pc_pend;
  logic     w_mem_stall;
  logic     w_mem_err;

  mem_wait_fsm #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait (
    .clk         (clk),
    .reset       (reset),
    .i_req       (hif.MemReqM),
    .i_ack       (hif.MemAckM),
    .o_mem_stall (w_mem_stall),
    .o_mem_err   (w_mem_err)
  );

  always_comb begin
    w_fwd_a     = fwd_sel(hif.RA1E, hif.WA3M, hif.RegWriteM, hif.WA3W, hif.RegWriteW);
    w_fwd_b     = fwd_sel(hif.RA2E, hif.WA3M, hif.RegWriteM, hif.WA3W, hif.RegWriteW);
    w_ldr_stall = hif.MemToRegE && hif.RegWriteE &&
                  ((hif.RA1D == hif.WA3E) || (hif.RA2D == hif.WA3E));
    w_pc_pend   = hif.PCSrcD | hif.PCSrcE | hif.PCSrcM;
  end

  always_comb begin
    hif.ForwardAE = FWD_RF;
    hif.ForwardBE = FWD_RF;
    hif.StallF    = 1'b0;
    hif.StallD    = 1'b0;
    hif.StallE    = 1'b0;
    hif.StallM    = 1'b0;
    hif.FlushD    = 1'b1;
    hif.FlushE    = 1'b1;
    hif.FlushW    = 1'b1;
    hif.MemErr    = 1'b0;
    if (reset) begin
      hif.ForwardAE = w_fwd_a;
      hif.ForwardBE = w_fwd_b;
      hif.StallM    = w_mem_stall;
      hif.StallE    = w_mem_stall;
      hif.StallD    = w_mem_stall | w_ldr_stall;
      hif.StallF    = w_mem_stall | w_ldr_stall | w_pc_pend;
      hif.FlushW    = w_mem_stall;
      // A frozen M stage holds E/D too, so their flushes wait until it releases.
      hif.FlushE    = !w_mem_stall & (w_ldr_stall | hif.BranchTakenE);
      hif.FlushD    = !w_mem_stall & (w_pc_pend | hif.PCSrcW | hif.BranchTakenE);
      hif.MemErr    = w_mem_err;
    end
  end

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (hif.StallD && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if ((hif.FlushD || hif.FlushE) && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

  assign hif.StallCnt = r_stall_cnt;
  assign hif.FlushCnt = r_flush_cnt;
`else
  assign hif.StallCnt = '0;
  assign hif.FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, multi-cycle memory sequences and
// randomized traffic against a rule-level reference model.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hif();

  hazard_ctrl #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_dut (
    .clk   (clk),
    .reset (rst_n),
    .hif   (hif)
  );

  typedef struct packed {
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic rwe, rwm, rww, m2re, pcd, pce, pcm, pcw, bte, req, ack, rst_n;
  } in_t;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic sf, sd, se, sm, fd, fe, fw, err;
  } out_t;

  typedef struct packed {
    in_t  v;
    out_t e;
  } vec_t;

  vec_t tv [12];
  int   n_vec = 0;
  int   n_err = 0;
  out_t got;

  // Reference model state: an access is either pending (busy, with a count of
  // WAIT cycles already spent) or has just been abandoned (tmo).
  bit               m_busy = 0;
  bit               m_tmo  = 0;
  int               m_waited = 0;
  logic [CNT_W-1:0] m_scnt = '0;
  logic [CNT_W-1:0] m_fcnt = '0;

  function automatic in_t base();
    in_t v;
    v       = '0;
    v.rst_n = 1'b1;
    return v;
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [3:0] ra, input in_t v);
    if (ra == 4'd15) return 2'b00;
    if (v.rwm && v.wa3m == ra) return 2'b10;
    if (v.rww && v.wa3w == ra) return 2'b01;
    return 2'b00;
  endfunction

  function automatic out_t ref_out(input in_t v);
    out_t o;
    bit   ms, ldr, pend;
    o = '0;
    if (!v.rst_n) begin
      o.fd = 1'b1; o.fe = 1'b1; o.fw = 1'b1;
      return o;
    end
    ldr  = v.m2re && v.rwe && (v.ra1d == v.wa3e || v.ra2d == v.wa3e);
    pend = v.pcd || v.pce || v.pcm;
    ms   = !m_tmo && (m_busy || (v.req && !v.ack));
    o.fa  = ref_fwd(v.ra1e, v);
    o.fb  = ref_fwd(v.ra2e, v);
    o.sm  = ms;
    o.se  = ms;
    o.sd  = ms || ldr;
    o.sf  = ms || ldr || pend;
    o.fw  = ms;
    o.fe  = !ms && (ldr || v.bte);
    o.fd  = !ms && (pend || v.pcw || v.bte);
    o.err = m_tmo;
    return o;
  endfunction

  task automatic model_tick(input in_t v, input out_t e);
    if (!v.rst_n) begin
      m_busy = 0; m_tmo = 0; m_waited = 0; m_scnt = '0; m_fcnt = '0;
      return;
    end
    if (e.sd && m_scnt != '1) m_scnt = m_scnt + 1;
    if ((e.fd || e.fe) && m_fcnt != '1) m_fcnt = m_fcnt + 1;
    if (m_tmo) begin
      m_tmo = 0;
    end else if (m_busy) begin
      if (v.ack) begin
        m_busy = 0;
      end else begin
        m_waited++;
        if (m_waited == MEM_TIMEOUT) begin
          m_busy = 0;
          m_tmo  = 1;
        end
      end
    end else if (v.req && !v.ack) begin
      m_busy   = 1;
      m_waited = 0;
    end
  endtask

  task automatic drive(input in_t v);
    hif.RA1D = v.ra1d; hif.RA2D = v.ra2d; hif.RA1E = v.ra1e; hif.RA2E = v.ra2e;
    hif.WA3E = v.wa3e; hif.WA3M = v.wa3m; hif.WA3W = v.wa3w;
    hif.RegWriteE = v.rwe; hif.RegWriteM = v.rwm; hif.RegWriteW = v.rww;
    hif.MemToRegE = v.m2re;
    hif.PCSrcD = v.pcd; hif.PCSrcE = v.pce; hif.PCSrcM = v.pcm; hif.PCSrcW = v.pcw;
    hif.BranchTakenE = v.bte;
    hif.MemReqM = v.req; hif.MemAckM = v.ack;
    rst_n = v.rst_n;
  endtask

  task automatic chk(input string name, input int actual, input int required);
    n_vec++;
    if (actual != required) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, actual, required);
    end
  endtask

  task automatic step(input in_t v, input out_t e, input string name);
    @(negedge clk);
    drive(v);
    #1;
    got = {hif.ForwardAE, hif.ForwardBE, hif.StallF, hif.StallD, hif.StallE,
           hif.StallM, hif.FlushD, hif.FlushE, hif.FlushW, hif.MemErr};
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, e);
    end
    n_vec++;
`ifdef HAZARD_PERF_EN
    if (hif.StallCnt !== m_scnt || hif.FlushCnt !== m_fcnt) begin
      n_err++;
      $display("FAIL %s_cnt: got %0d/%0d required %0d/%0d", name,
               hif.StallCnt, hif.FlushCnt, m_scnt, m_fcnt);
    end
`else
    if (hif.StallCnt !== '0 || hif.FlushCnt !== '0) begin
      n_err++;
      $display("FAIL %s_cnt: got %0d/%0d required 0/0", name, hif.StallCnt, hif.FlushCnt);
    end
`endif
    model_tick(v, e);
  endtask

  task automatic step_m(input in_t v, input string name);
    step(v, ref_out(v), name);
  endtask

  function automatic logic [3:0] raddr();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'd15 : 4'(r);
  endfunction

  initial begin
    in_t  v;
    out_t e;
    int   stalls, errs, seen, fe_bad, fe_after;

    // Directed vectors; the memory FSM stays idle throughout.
    for (int i = 0; i < 12; i++) begin
      tv[i].v = base();
      tv[i].e = '0;
    end
    tv[0].v.rwm = 1; tv[0].v.wa3m = 3; tv[0].v.rww = 1; tv[0].v.wa3w = 3; tv[0].v.ra1e = 3;
    tv[0].e.fa = 2'b10;
    tv[1].v = tv[0].v; tv[1].v.rwm = 0;
    tv[1].e.fa = 2'b01;
    tv[2].v = tv[0].v; tv[2].v.wa3m = 15; tv[2].v.wa3w = 15; tv[2].v.ra1e = 15;
    tv[3].v.rww = 1; tv[3].v.wa3w = 5; tv[3].v.ra2e = 5; tv[3].v.ra1e = 6;
    tv[3].e.fb = 2'b01;
    tv[4].v.m2re = 1; tv[4].v.rwe = 1; tv[4].v.wa3e = 2; tv[4].v.ra2d = 2; tv[4].v.ra1d = 7;
    tv[4].e.sf = 1; tv[4].e.sd = 1; tv[4].e.fe = 1;
    tv[5].v = tv[4].v; tv[5].v.ra2d = 4;
    tv[6].v.bte = 1;
    tv[6].e.fd = 1; tv[6].e.fe = 1;
    tv[7].v.pcd = 1;
    tv[7].e.sf = 1; tv[7].e.fd = 1;
    tv[8].v.pcw = 1;
    tv[8].e.fd = 1;
    tv[9].v = tv[4].v; tv[9].v.bte = 1;
    tv[9].e.sf = 1; tv[9].e.sd = 1; tv[9].e.fe = 1; tv[9].e.fd = 1;
    tv[10].v = tv[9].v; tv[10].v.rst_n = 0; tv[10].v.rwm = 1; tv[10].v.wa3m = 0;
    tv[10].e.fd = 1; tv[10].e.fe = 1; tv[10].e.fw = 1;
    tv[11].v = tv[4].v; tv[11].v.rwe = 0;

    v = base();
    v.rst_n = 0;
    drive(v);
    repeat (2) @(posedge clk);

    for (int i = 0; i < 12; i++) step(tv[i].v, tv[i].e, $sformatf("tv%0d", i));

    // Memory wait: ack on the 4th cycle, stalls for exactly 4 cycles.
    v = base(); v.req = 1; stalls = 0; errs = 0;
    for (int i = 0; i < 8; i++) begin
      v.ack = (i == 3);
      if (i > 3) v.req = 0;
      step_m(v, "memwait");
      stalls += int'(got.sm && got.sf && got.sd && got.se && got.fw);
      errs   += int'(got.err);
    end
    chk("memwait_stall_cycles", stalls, 4);
    chk("memwait_err", errs, 0);

    // Timeout: 1 detect + MEM_TIMEOUT WAIT stall cycles, then a single MemErr.
    v = base(); v.req = 1; stalls = 0; seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      step_m(v, "timeout");
      if (got.err) seen = 1;
      else if (got.sm) stalls++;
    end
    chk("timeout_seen", seen, 1);
    chk("timeout_stall_cycles", stalls, MEM_TIMEOUT + 1);
    chk("timeout_err_stall", int'(got.sm), 0);
    v.req = 0;
    step_m(v, "timeout_after");
    chk("timeout_err_width", int'(got.err), 0);

    // Reset pulled mid-WAIT aborts silently.
    v = base(); v.req = 1; errs = 0;
    repeat (5) step_m(v, "rst_wait");
    v.rst_n = 0;
    step_m(v, "rst_assert");
    v.rst_n = 1; v.req = 0;
    for (int i = 0; i < 3; i++) begin
      step_m(v, "rst_after");
      errs += int'(got.err) + int'(got.sm);
    end
    chk("rst_midwait_quiet", errs, 0);

    // Branch in E frozen behind a memory stall is flushed once the stall drops.
    v = base(); v.bte = 1; v.req = 1; fe_bad = 0; fe_after = 0;
    for (int i = 0; i < 5; i++) begin
      v.ack = (i == 2);
      if (i > 2) v.req = 0;
      step_m(v, "prio");
      if (got.sm && got.fe) fe_bad++;
      if (i == 3) fe_after = int'(got.fe);
    end
    chk("prio_fe_while_stalled", fe_bad, 0);
    chk("prio_fe_after_ack", fe_after, 1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      v = base();
      v.ra1d = raddr(); v.ra2d = raddr(); v.ra1e = raddr(); v.ra2e = raddr();
      v.wa3e = raddr(); v.wa3m = raddr(); v.wa3w = raddr();
      v.rwe  = 1'($urandom); v.rwm = 1'($urandom); v.rww = 1'($urandom);
      v.m2re = 1'($urandom);
      v.pcd  = ($urandom_range(0, 7) == 0); v.pce = ($urandom_range(0, 7) == 0);
      v.pcm  = ($urandom_range(0, 7) == 0); v.pcw = ($urandom_range(0, 7) == 0);
      v.bte  = ($urandom_range(0, 5) == 0);
      v.req  = ($urandom_range(0, 2) != 0);
      v.ack  = ($urandom_range(0, 9) == 0);
      v.rst_n = ($urandom_range(0, 99) != 0);
      step_m(v, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
